// File: rtl/serial_uart_bridge_pkg.sv
// Shared definitions for the serial UART bridge: FSM state encoding and framing constants.
package serial_uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned IDX_W     = 3;
  localparam logic        LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_uart_bridge_byte_fifo.sv
// First-word fall-through byte FIFO; a push into a full FIFO is taken only alongside a pop.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// Processor-to-pin UART bridge: TX FIFO feeding an 8N1 serialiser, RX deserialiser feeding an RX FIFO.
module serial_uart_bridge
  import serial_uart_bridge_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic             tx_full;
  logic             tx_empty;
  logic [7:0]       tx_head;
  logic             tx_pop_c;
  uart_state_e      tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [IDX_W-1:0] tx_idx;
  logic [7:0]       tx_shift;

  logic             rx_full;
  logic             rx_empty;
  logic [7:0]       rx_head;
  logic             rx_pop_c;
  logic             rx_push;
  logic             rx_meta;
  logic             rx_sync;
  uart_state_e      rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [IDX_W-1:0] rx_idx;
  logic [7:0]       rx_shift;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_wren_in),
    .push_data (tx_data_in),
    .pop       (tx_pop_c),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop_c),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  assign tx_ready_out = !tx_full;
  assign rx_valid_out = !rx_empty;
  assign rx_data_out  = rx_empty ? 8'h00 : rx_head;
  assign rx_pop_c     = rx_rden_in && !rx_empty;
  // Load the next byte when idle, or straight out of STOP so frames run back to back.
  assign tx_pop_c     = !tx_empty && ((tx_state == ST_IDLE) ||
                                      ((tx_state == ST_STOP) && (tx_cnt == '0)));

  // TX serialiser: the line level is a register updated at each bit boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state    <= ST_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
      uart_tx_out <= LINE_IDLE;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (!tx_empty) begin
            tx_shift    <= tx_head;
            tx_cnt      <= BIT_LAST;
            uart_tx_out <= 1'b0;
            tx_state    <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == '0) begin
            tx_cnt      <= BIT_LAST;
            tx_idx      <= '0;
            uart_tx_out <= tx_shift[0];
            tx_state    <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == IDX_LAST) begin
              uart_tx_out <= LINE_IDLE;
              tx_state    <= ST_STOP;
            end else begin
              tx_idx      <= tx_idx + IDX_ONE;
              uart_tx_out <= tx_shift[tx_idx + IDX_ONE];
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (tx_cnt == '0) begin
            if (!tx_empty) begin
              tx_shift    <= tx_head;
              tx_cnt      <= BIT_LAST;
              uart_tx_out <= 1'b0;
              tx_state    <= ST_START;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous RX pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= LINE_IDLE;
      rx_sync <= LINE_IDLE;
    end else begin
      rx_meta <= uart_rx_in;
      rx_sync <= rx_meta;
    end
  end

  // RX deserialiser: samples at mid-bit; the FIFO push lands one cycle after the stop sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state         <= ST_IDLE;
      rx_cnt           <= '0;
      rx_idx           <= '0;
      rx_shift         <= '0;
      rx_push          <= 1'b0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      if (rx_push && rx_full && !rx_pop_c) rx_overrun_out <= 1'b1;
      case (rx_state)
        ST_IDLE: begin
          if (!rx_sync) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == '0) begin
            if (rx_sync) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
              rx_state <= ST_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift[rx_idx] <= rx_sync;
            rx_cnt           <= BIT_LAST;
            if (rx_idx == IDX_LAST) rx_state <= ST_STOP;
            else                    rx_idx   <= rx_idx + IDX_ONE;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (rx_cnt == '0) begin
            if (rx_sync) rx_push          <= 1'b1;
            else         rx_frame_err_out <= 1'b1;
            rx_state <= ST_IDLE;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Self-checking bench: transaction-level UART/FIFO model compared every cycle, plus pinned literal checks.
module tb_serial_uart_bridge;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  // Edges from the RX start-bit drive to the stop-bit mid-sample: 2 sync flops, 1 detect, half bit, 9 bits.
  localparam int RX_STOP_LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_wren_in = 1'b0;
  logic       rx_rden_in = 1'b0;
  logic       uart_rx_in = 1'b1;
  logic       tx_ready_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       uart_tx_out;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  always #5 clock = ~clock;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .tx_data_in       (tx_data_in),
    .tx_wren_in       (tx_wren_in),
    .tx_ready_out     (tx_ready_out),
    .rx_data_out      (rx_data_out),
    .rx_valid_out     (rx_valid_out),
    .rx_rden_in       (rx_rden_in),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  typedef struct {
    int         due;
    bit         ferr;
    logic [7:0] data;
  } rx_ev_t;

  rx_ev_t     evq[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] cur = 8'h00;
  int         tx_t = -1;
  int         cyc = 0;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  bit         m_live = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %02h, want %02h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  // Reference model: advances at each clock edge from the inputs the DUT samples.
  always @(posedge clock) begin
    bit     start;
    rx_ev_t e;
    cyc++;
    if (reset) begin
      txq.delete();
      rxq.delete();
      evq.delete();
      tx_t   = -1;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      m_live = 1'b1;
    end else begin
      start = 1'b0;
      if (tx_t < 0 || tx_t == FRAME - 1) begin
        start = (txq.size() > 0);
        tx_t  = start ? 0 : -1;
      end else begin
        tx_t++;
      end
      if (start) cur = txq.pop_front();
      if (tx_wren_in && txq.size() < DEPTH) txq.push_back(tx_data_in);
      if (rx_rden_in && rxq.size() > 0) void'(rxq.pop_front());
      while (evq.size() > 0 && evq[0].due <= cyc) begin
        e = evq.pop_front();
        if (e.ferr)                  m_ferr = 1'b1;
        else if (rxq.size() < DEPTH) rxq.push_back(e.data);
        else                         m_ovr = 1'b1;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clock) begin
    logic       e_line;
    logic [7:0] e_data;
    if (m_live) begin
      e_line = (tx_t < 0) ? 1'b1 : frame_bit(cur, tx_t / CPB);
      e_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
      chk1("uart_tx_out", uart_tx_out, e_line);
      chk1("tx_ready_out", tx_ready_out, txq.size() < DEPTH);
      chk1("rx_valid_out", rx_valid_out, rxq.size() > 0);
      chk("rx_data_out", rx_data_out, e_data);
      chk1("rx_frame_err_out", rx_frame_err_out, m_ferr);
      chk1("rx_overrun_out", rx_overrun_out, m_ovr);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one RX frame plus a two-bit idle gap; pop_c pulses rx_rden_in, rnd adds random host traffic.
  task automatic rx_frame(input logic [7:0] d, input logic stop, input int pop_c, input bit rnd);
    rx_ev_t e;
    for (int c = 0; c < FRAME + 2 * CPB; c++) begin
      int b;
      b = c / CPB;
      if (c == 0) begin
        e.due  = cyc + RX_STOP_LAT + (stop ? 1 : 0);
        e.ferr = !stop;
        e.data = d;
        evq.push_back(e);
      end
      if (b == 0)      uart_rx_in = 1'b0;
      else if (b <= 8) uart_rx_in = d[b-1];
      else if (b == 9) uart_rx_in = stop;
      else             uart_rx_in = 1'b1;
      rx_rden_in = (c == pop_c);
      tx_wren_in = 1'b0;
      if (rnd) begin
        tx_wren_in = ($urandom_range(15) == 0);
        tx_data_in = 8'($urandom);
        if ($urandom_range(7) == 0) rx_rden_in = 1'b1;
      end
      tick();
    end
    rx_rden_in = 1'b0;
    tx_wren_in = 1'b0;
  endtask

  task automatic rx_pop();
    rx_rden_in = 1'b1;
    tick();
    rx_rden_in = 1'b0;
  endtask

  initial begin
    logic       a5_bits [8];
    logic [7:0] exp_q [4];
    int         n0;
    a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_q   = '{8'h22, 8'h33, 8'h44, 8'h66};

    // Reset values
    repeat (3) tick();
    chk1("rst_tx_line", uart_tx_out, 1'b1);
    chk1("rst_tx_ready", tx_ready_out, 1'b1);
    chk1("rst_rx_valid", rx_valid_out, 1'b0);
    chk("rst_rx_data", rx_data_out, 8'h00);
    chk1("rst_ferr", rx_frame_err_out, 1'b0);
    chk1("rst_ovr", rx_overrun_out, 1'b0);
    reset = 1'b0;
    tick();

    // TX single byte 0xA5
    tx_data_in = 8'hA5;
    tx_wren_in = 1'b1;
    for (int c = 1; c <= 170; c++) begin
      tick();
      tx_wren_in = 1'b0;
      if (c == 1) chk1("a5_pre_start", uart_tx_out, 1'b1);
      if (c == 2) chk1("a5_start", uart_tx_out, 1'b0);
      for (int j = 0; j < 8; j++)
        if (c == 2 + 16 * (j + 1) + 8) chk1("a5_data_bit", uart_tx_out, a5_bits[j]);
      if (c == 161) chk1("a5_stop", uart_tx_out, 1'b1);
      if (c == 162) chk1("a5_idle", uart_tx_out, 1'b1);
    end

    // TX back-to-back pushes 0x01..0x06 into a 4-deep FIFO
    n0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      tx_data_in = 8'(i);
      tx_wren_in = 1'b1;
      tick();
      if (i == 5) chk1("b2b_full", tx_ready_out, 1'b0);
    end
    tx_wren_in = 1'b0;
    while (cyc < n0 + 161) tick();
    chk1("b2b_stop_end", uart_tx_out, 1'b1);
    tick();
    chk1("b2b_no_gap", uart_tx_out, 1'b0);
    repeat (4 * FRAME + 20) tick();

    // RX loopback 0x3C and pop
    rx_frame(8'h3C, 1'b1, -1, 1'b0);
    chk1("lb_valid", rx_valid_out, 1'b1);
    chk("lb_data", rx_data_out, 8'h3C);
    rx_pop();
    chk1("lb_pop_valid", rx_valid_out, 1'b0);
    chk("lb_pop_data", rx_data_out, 8'h00);

    // RX 3-cycle glitch, then framing error
    uart_rx_in = 1'b0;
    repeat (3) tick();
    uart_rx_in = 1'b1;
    repeat (2 * CPB) tick();
    chk1("glitch_valid", rx_valid_out, 1'b0);
    chk1("glitch_ferr", rx_frame_err_out, 1'b0);
    rx_frame(8'h55, 1'b0, -1, 1'b0);
    chk1("ferr_flag", rx_frame_err_out, 1'b1);
    chk1("ferr_empty", rx_valid_out, 1'b0);

    // RX overrun: five frames with no pops, then push and pop together at full
    for (int i = 1; i <= 5; i++) rx_frame(8'(i * 8'h11), 1'b1, -1, 1'b0);
    chk1("ovr_flag", rx_overrun_out, 1'b1);
    chk("ovr_head", rx_data_out, 8'h11);
    rx_frame(8'h66, 1'b1, RX_STOP_LAT, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_order", rx_data_out, exp_q[i]);
      rx_pop();
    end
    chk1("ovr_drained", rx_valid_out, 1'b0);

    // Random host traffic with random RX frames, some with a bad stop bit
    for (int f = 0; f < 10; f++)
      rx_frame(8'($urandom), ($urandom_range(4) != 0), -1, 1'b1);
    repeat (5 * FRAME + 20) tick();

    // Reset in the middle of a TX frame's data bits
    rx_frame(8'hC3, 1'b1, -1, 1'b0);
    tx_data_in = 8'h5A;
    tx_wren_in = 1'b1;
    tick();
    tx_wren_in = 1'b0;
    repeat (40) tick();
    reset = 1'b1;
    tick();
    chk1("mid_rst_tx_line", uart_tx_out, 1'b1);
    chk1("mid_rst_tx_ready", tx_ready_out, 1'b1);
    chk1("mid_rst_rx_valid", rx_valid_out, 1'b0);
    chk1("mid_rst_ferr", rx_frame_err_out, 1'b0);
    chk1("mid_rst_ovr", rx_overrun_out, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
